// File: rtl/temp_sensor_sampler_if.sv
// Sensor link and filtered-temperature bus of the temperature sampler.
//   enable       : periodic conversions run while high (consumer -> sampler)
//   sensor_miso  : serial data from sensor, MSB first
//   sensor_sclk  : serial clock to sensor, idles low
//   sensor_cs_n  : sensor chip select, active-low
//   temperature  : filtered temperature, degrees C
//   temp_valid   : one-cycle update pulse
//   sensor_fault : all-ones frame seen, cleared by the next good frame
interface temp_sensor_sampler_if;
    logic       enable;
    logic       sensor_miso;
    logic       sensor_sclk;
    logic       sensor_cs_n;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       sensor_fault;

    // Sampler side
    modport master (
        input  enable,
        input  sensor_miso,
        output sensor_sclk,
        output sensor_cs_n,
        output temperature,
        output temp_valid,
        output sensor_fault
    );

    // Consumer / sensor side
    modport slave (
        output enable,
        output sensor_miso,
        input  sensor_sclk,
        input  sensor_cs_n,
        input  temperature,
        input  temp_valid,
        input  sensor_fault
    );
endinterface

// File: rtl/temp_sensor_sampler.sv
// Periodically reads an 8-bit serial temperature sensor, clamps the code to
// 5 bits and presents a 4-sample moving average to the thermostat.
//   clk : system clock, rising edge
//   rst : synchronous reset, active-high
//   bus : temp_sensor_sampler_if.master (sensor link + filtered output)
module temp_sensor_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter logic [4:0]  RESET_TEMP    = 5'd20
) (
    input  logic                  clk,
    input  logic                  rst,
    temp_sensor_sampler_if.master bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        CALC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic             start_q;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       half_cnt;
    logic [7:0]       shreg;
    // Three most recent samples; with the incoming sample they form the
    // 4-entry averaging window, so the oldest entry never needs storing.
    logic [2:0][4:0]  hist;

    logic             sclk;
    logic             cs_n;
    logic [4:0]       temperature;
    logic             temp_valid;
    logic             sensor_fault;

    logic [4:0]       sample_c;
    logic [6:0]       sum_c;

    // Clamp the frame code and sum the window that results from shifting it in
    always_comb begin
        sample_c = (shreg > 8'd31) ? 5'd31 : shreg[4:0];
        sum_c    = 7'(sample_c) + 7'(hist[0]) + 7'(hist[1]) + 7'(hist[2]);
    end

    // Period counter, frame sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            period_cnt   <= '0;
            start_q      <= 1'b0;
            div_cnt      <= '0;
            half_cnt     <= '0;
            shreg        <= '0;
            hist         <= {3{RESET_TEMP}};
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            temperature  <= RESET_TEMP;
            temp_valid   <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            temp_valid <= 1'b0;

            if (!bus.enable || period_cnt == CNT_LAST) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + CNT_W'(1);
            end
            // Registered terminal count: cs_n falls a full period after enable
            start_q <= bus.enable && (period_cnt == CNT_LAST);

            case (state)
                IDLE: begin
                    // Triggers arriving outside IDLE are simply ignored
                    if (start_q && bus.enable) begin
                        state   <= SETUP;
                        cs_n    <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        state    <= SHIFT;
                        div_cnt  <= '0;
                        half_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // Sample on the edge that raises sclk
                        if (!sclk) begin
                            shreg <= {shreg[6:0], bus.sensor_miso};
                        end
                        if (half_cnt == 4'd15) begin
                            state <= HOLD;
                        end else begin
                            half_cnt <= half_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= CALC;
                        cs_n    <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                CALC: begin
                    state <= IDLE;
                    // All-ones means a floating or broken sensor line
                    if (shreg == 8'hFF) begin
                        sensor_fault <= 1'b1;
                    end else begin
                        sensor_fault <= 1'b0;
                        hist         <= {hist[1:0], sample_c};
                        temperature  <= 5'(sum_c >> 2);
                        temp_valid   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sensor_sclk  = sclk;
    assign bus.sensor_cs_n  = cs_n;
    assign bus.temperature  = temperature;
    assign bus.temp_valid   = temp_valid;
    assign bus.sensor_fault = sensor_fault;

endmodule

// File: doc/temp_sensor_sampler.md
Name: temp_sensor_sampler

Overview:
- Upstream feeder for the thermostat controller. Polls a serial 8-bit temperature sensor over a 3-wire SPI-style link at a fixed rate.
- Clamps each reading to the 5-bit range and smooths it with a 4-sample moving average.
- Presents temperature[4:0] in the exact form the thermostat's temperature inputs consume. Flags a disconnected or faulty sensor.

Parameters:
CLK_DIV, 4, clk cycles per sensor_sclk half-period (>=2)
SAMPLE_PERIOD, 1000, clk cycles between conversion start triggers (>= 18*CLK_DIV+2)
RESET_TEMP, 5'd20, temperature and history value after reset (inside thermostat dead band)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  high = periodic conversions run
sensor_miso  input  1  serial data from sensor, MSB first
sensor_sclk  output  1  serial clock to sensor, idles low
sensor_cs_n  output  1  sensor chip select, active-low, idles high
temperature  output  5  filtered temperature, degrees C, unsigned
temp_valid  output  1  one-cycle pulse when temperature updates
sensor_fault  output  1  high after an all-ones frame, until the next good frame

Behaviour:
- Reset values: sensor_sclk=0, sensor_cs_n=1, temperature=RESET_TEMP, temp_valid=0, sensor_fault=0.
- Reset also sets all 4 history entries to RESET_TEMP, the period counter to 0 and the FSM to IDLE.
- Reset asserted mid-frame aborts the frame. The next cycle shows all reset values.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1.
  - Held at 0 while enable=0.
  - Terminal count raises the start trigger. sensor_cs_n therefore falls SAMPLE_PERIOD cycles after enable is first sampled high.
- Start trigger in any state other than IDLE is dropped. The counter is not stalled.
- enable falling mid-frame: the current frame completes normally, including CALC. No further starts.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> CALC -> IDLE.
- IDLE:
  - cs_n=1, sclk=0.
  - Leaves on the start trigger.
- SETUP:
  - cs_n=0, sclk=0, for CLK_DIV cycles.
  - The sensor's first bit is valid by the end of SETUP.
- SHIFT:
  - 16 half-periods of CLK_DIV cycles each. sclk toggles at the end of each half-period, starting low.
  - Exactly 8 rising edges.
  - sensor_miso is captured into the shift register on the same clk edge that drives sensor_sclk 0->1, MSB first.
  - After the 16th half-period sclk=0 and the FSM moves to HOLD.
- HOLD:
  - cs_n=0, sclk=0, for CLK_DIV cycles.
  - cs_n=1 on entry to CALC.
  - cs_n is low for exactly 18*CLK_DIV cycles per frame.
- CALC (1 cycle), on the 8-bit code:
  - Code 8'hFF: sensor_fault<=1. History and temperature are unchanged. No temp_valid.
  - Any other code:
    - sensor_fault<=0.
    - sample = (code>31) ? 31 : code[4:0].
    - Shift the sample into the history; the oldest entry drops out.
    - temperature <= (h0+h1+h2+h3)>>2, using a 7-bit sum and truncating.
    - temp_valid<=1 for exactly one cycle.
    - The new temperature and temp_valid both appear in the cycle after CALC.
- temperature is constant between updates. temp_valid is never high for two consecutive cycles.
- sensor_sclk toggles only in SHIFT.

Test Plan:
- Reset check: hold rst 3 cycles -> sensor_cs_n=1, sensor_sclk=0, temperature=20, temp_valid=0, sensor_fault=0. Repeat with rst asserted mid-SHIFT -> same values next cycle.
- Frame timing: CLK_DIV=4, SAMPLE_PERIOD=200, enable=1 from reset release -> cs_n falls at cycle 200. cs_n stays low 72 cycles with exactly 8 sclk rising edges. Next cs_n fall at cycle 400.
- Averaging: sensor model returns 8'd24 on four consecutive frames -> temperature at each temp_valid = 21, 22, 23, 24. Then 8'd16 on four frames -> 22, 20, 18, 16.
- Clamp: from reset history, code 8'd40 -> temperature=22 (91>>2). Four frames of 8'd200 -> final temperature=31.
- Fault: code 8'hFF -> sensor_fault=1, no temp_valid, temperature unchanged. Following code 8'd20 -> sensor_fault=0, temp_valid pulses.
- Enable control: drop enable during SHIFT -> frame completes and temp_valid pulses once. No further cs_n activity while enable=0. Re-raise enable -> cs_n falls SAMPLE_PERIOD cycles later.
